apb_arb_master: RTL and testbench
=================================

Name: apb_arb_master

Overview:
- Two-requester APB master: round-robin arbitrates two local request ports onto one APB bus.
- Decodes the address to psel1/psel2 and sequences SETUP/ACCESS phases with wait-state support.
- Returns read data and error on a shared response port.
- Sits between internal bus users (CPU-side, DMA-side) and the APB slaves such as the slave1/slave2 memory peripherals.

Parameters:
ADDR_WIDTH, 32, local and APB address width
DATA_WIDTH, 32, data width
SLAVE_SEL_BIT, 8, address bit selecting slave (0 -> slave1, 1 -> slave2)
TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready before error termination

Ports:
pclk_i  in  1  clock; all logic on rising edge
prst_i  in  1  reset, synchronous, active-high
req_valid_i  in  2  request valid per requester; held until granted
req_write_i  in  2  1 = write, 0 = read, per requester
req_addr_i  in  2*ADDR_WIDTH  requester n at [n*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata_i  in  2*DATA_WIDTH  requester n at [n*DATA_WIDTH +: DATA_WIDTH]
req_grant_o  out  2  one-hot; request n accepted at this edge
rsp_valid_o  out  1  one-cycle response pulse
rsp_id_o  out  1  requester index owning the response
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  decode error or timeout
paddr_o  out  ADDR_WIDTH  slave-local address
psel1_o  out  1  select slave1
psel2_o  out  1  select slave2
penable_o  out  1  APB access phase
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pready1_i  in  1  slave1 ready
pready2_i  in  1  slave2 ready
prdata1_i  in  DATA_WIDTH  slave1 read data
prdata2_i  in  DATA_WIDTH  slave2 read data

Behaviour:
- Reset (prst_i high at an edge): state IDLE; all registered outputs 0; RR pointer favours requester 0; timeout counter 0. req_grant_o is forced 0 while prst_i is high.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is set, the arbiter picks one. When both are valid, the requester not granted last wins; a single valid requester always wins.
  - req_grant_o is combinational in IDLE and valid in the same cycle. At the edge the request is latched and the pointer is updated.
  - Decode: addr bits above SLAVE_SEL_BIT must be 0.
  - Decode error: no APB activity, state stays IDLE, next cycle rsp_valid=1, rsp_err=1, rdata=0.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - psel of the decoded slave =1, penable=0.
  - paddr_o = latched addr with bits [ADDR_WIDTH-1:SLAVE_SEL_BIT] cleared. pwrite/pwdata driven from the latch.
  - Next state ACCESS.
- ACCESS:
  - penable=1; psel, paddr, pwrite, pwdata held stable.
  - Each edge samples the selected slave's pready. If high: capture prdata (reads only), drop psel/penable, go IDLE.
  - Else increment the counter. At the edge where the count reaches TIMEOUT_CYCLES, terminate with rsp_err=1, rdata=0, go IDLE.
  - The non-selected slave's pready/prdata are ignored.
- Response: registered; rsp_valid high exactly one cycle, the first IDLE cycle after completion. Arbitration may grant a new request in that same cycle.
- Minimum transfer spacing: the next SETUP follows the prior ACCESS completion by ≥1 IDLE cycle.
- Reset mid-transfer: the transfer is aborted silently. psel/penable/rsp_valid are 0 after the reset edge and no response is issued.
- Requester changing req_valid_i or req_* after grant does not affect the latched transfer.

Decomposition:
- Package apb_pkg: state encodings (IDLE/SETUP/ACCESS), NUM_REQ=2, slave index constants.
- Sub-module apb_rr_arbiter: 2-input round-robin, combinational grant, registered priority pointer, advance input.

Test Plan:
1. req0 write addr 0x05 data 0xA5, slave1 pready=1 in the first ACCESS cycle -> grant[0] at T0; T1 psel1=1/penable=0/paddr=0x05; T2 penable=1; T3 rsp_valid=1, id=0, err=0.
2. req1 read addr 0x105, slave2 returns 0x3C after 2 wait states -> psel2=1, paddr_o=0x05, penable held 3 cycles, rsp_rdata=0x3C, id=1.
3. Both req_valid held high for 4 transfers from reset -> grant order 0,1,0,1; no overlapping psel.
4. req0 read addr 0x200 -> grant[0], psel1/psel2 stay 0, next cycle rsp_valid=1, err=1, rdata=0.
5. slave1 pready held 0 -> after exactly 16 ACCESS cycles psel1/penable drop, rsp_err=1, rdata=0; next request proceeds normally.
6. prst_i pulsed during ACCESS -> next cycle all outputs 0, no rsp_valid; with both valid afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the two-requester APB master
//
// Purpose: FSM state encoding, requester count and slave index constants used
// by apb_arb_master and apb_rr_arbiter.
// Ports: none (package).

package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int NUM_REQ = 2;

  // Value of the slave-select address bit for each slave.
  localparam logic SLV1 = 1'b0;
  localparam logic SLV2 = 1'b1;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - two-input round-robin arbiter
//
// Purpose: combinational one-hot grant; when both requesters are valid the one
// not granted last wins. The pointer moves only when advance_i is high.
// Ports:
//   pclk_i     clock
//   prst_i     synchronous active-high reset (pointer favours requester 0)
//   req_i      request vector
//   advance_i  a grant is being taken at this edge
//   grant_o    one-hot grant (0 when no request)

module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // Index of the requester granted most recently. Reset to 1 so that
  // requester 0 wins the first contended round.
  logic last_q;

  always_comb begin
    grant_o = '0;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - round-robin two-requester APB master with timeout
//
// Purpose: arbitrates two local request ports onto one APB bus with two
// slaves, decodes the target slave from address bit SLAVE_SEL_BIT, runs the
// SETUP/ACCESS sequence with wait states and timeout, and returns a one-cycle
// registered response.
// Ports:
//   pclk_i, prst_i                   clock, synchronous active-high reset
//   req_valid_i/write/addr/wdata     per-requester request (packed x2)
//   req_grant_o                      combinational one-hot grant in IDLE
//   rsp_valid_o/id/rdata/err         response pulse
//   paddr_o, psel1_o, psel2_o, penable_o, pwrite_o, pwdata_o   APB request
//   pready1_i, pready2_i, prdata1_i, prdata2_i                 APB returns

module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVE_SEL_BIT  = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk_i,
  input  logic                    prst_i,
  input  logic [1:0]              req_valid_i,
  input  logic [1:0]              req_write_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]              req_grant_o,
  output logic                    rsp_valid_o,
  output logic                    rsp_id_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel1_o,
  output logic                    psel2_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  input  logic                    pready1_i,
  input  logic                    pready2_i,
  input  logic [DATA_WIDTH-1:0]   prdata1_i,
  input  logic [DATA_WIDTH-1:0]   prdata2_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
    ADDR_WIDTH'((64'd1 << SLAVE_SEL_BIT) - 64'd1);

  apb_state_t             state_q;
  logic [1:0]             arb_grant;
  logic                   sel_slv_q;
  logic                   cur_id_q;
  logic [CNT_W-1:0]       to_cnt_q;

  logic                   gnt_id;
  logic [ADDR_WIDTH-1:0]  gnt_addr;
  logic [DATA_WIDTH-1:0]  gnt_wdata;
  logic                   gnt_write;
  logic                   dec_ok;
  logic                   pready_sel;
  logic [DATA_WIDTH-1:0]  prdata_sel;

  apb_rr_arbiter u_arb (
    .pclk_i    (pclk_i),
    .prst_i    (prst_i),
    .req_i     (req_valid_i),
    .advance_i (|req_grant_o),
    .grant_o   (arb_grant)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign req_grant_o = (state_q == ST_IDLE && !prst_i) ? arb_grant : 2'b00;

  assign gnt_id    = arb_grant[1];
  assign gnt_addr  = gnt_id ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign gnt_wdata = gnt_id ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
  assign gnt_write = gnt_id ? req_write_i[1] : req_write_i[0];

  // Only the select bit and the slave-local bits below it may be set.
  assign dec_ok = (gnt_addr >> (SLAVE_SEL_BIT + 1)) == '0;

  assign pready_sel = (sel_slv_q == SLV2) ? pready2_i : pready1_i;
  assign prdata_sel = (sel_slv_q == SLV2) ? prdata2_i : prdata1_i;

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q     <= ST_IDLE;
      sel_slv_q   <= 1'b0;
      cur_id_q    <= 1'b0;
      to_cnt_q    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      paddr_o     <= '0;
      psel1_o     <= 1'b0;
      psel2_o     <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_grant_o) begin
            cur_id_q <= gnt_id;
            if (!dec_ok) begin
              // Decode error: answer directly from IDLE without touching the bus.
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_id_o    <= gnt_id;
            end else begin
              sel_slv_q <= gnt_addr[SLAVE_SEL_BIT];
              paddr_o   <= gnt_addr & LOW_MASK;
              pwrite_o  <= gnt_write;
              pwdata_o  <= gnt_wdata;
              psel1_o   <= (gnt_addr[SLAVE_SEL_BIT] == SLV1);
              psel2_o   <= (gnt_addr[SLAVE_SEL_BIT] == SLV2);
              state_q   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable_o <= 1'b1;
          to_cnt_q  <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_sel || to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            psel1_o     <= 1'b0;
            psel2_o     <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= cur_id_q;
            rsp_err_o   <= !pready_sel;
            rsp_rdata_o <= (pready_sel && !pwrite_o) ? prdata_sel : '0;
            state_q     <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - directed self-checking bench for apb_arb_master

module tb_apb_arb_master;

  logic        pclk_i = 1'b0;
  logic        prst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_write_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  req_grant_o;
  logic        rsp_valid_o;
  logic        rsp_id_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic        psel1_o;
  logic        psel2_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        pready1_i;
  logic        pready2_i;
  logic [31:0] prdata1_i;
  logic [31:0] prdata2_i;

  int n_checks = 0;
  int n_errors = 0;

  apb_arb_master dut (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_grant_o (req_grant_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .paddr_o     (paddr_o),
    .psel1_o     (psel1_o),
    .psel2_o     (psel2_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pready1_i   (pready1_i),
    .pready2_i   (pready2_i),
    .prdata1_i   (prdata1_i),
    .prdata2_i   (prdata2_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_write_i[idx]         = wr;
    req_addr_i[idx*32 +: 32]  = addr;
    req_wdata_i[idx*32 +: 32] = wdata;
  endtask

  initial begin
    int cnt;
    prst_i      = 1'b1;
    req_valid_i = 2'b11;
    req_write_i = 2'b00;
    req_addr_i  = '0;
    req_wdata_i = '0;
    pready1_i   = 1'b0;
    pready2_i   = 1'b0;
    prdata1_i   = 32'hFF;
    prdata2_i   = 32'hEE;
    tick();
    tick();

    // Reset state: grant suppressed while reset is high, outputs cleared.
    check("rst_grant", {30'd0, req_grant_o}, 32'h0);
    check("rst_psel", {30'd0, psel2_o, psel1_o}, 32'h0);
    check("rst_penable", {31'd0, penable_o}, 32'h0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'h0);
    check("rst_paddr", paddr_o, 32'h0);
    req_valid_i = 2'b00;
    prst_i      = 1'b0;
    tick();

    // 1: req0 write 0x05 / 0xA5, zero wait states.
    set_req(0, 1'b1, 32'h05, 32'hA5);
    pready1_i   = 1'b1;
    req_valid_i = 2'b01;
    #1;
    check("t1_grant", {30'd0, req_grant_o}, 32'h1);
    tick();
    req_valid_i = 2'b00;
    check("t1_setup_sel", {29'd0, psel2_o, psel1_o, penable_o}, 32'b010);
    check("t1_paddr", paddr_o, 32'h05);
    check("t1_pwrite", {31'd0, pwrite_o}, 32'h1);
    check("t1_pwdata", pwdata_o, 32'hA5);
    tick();
    check("t1_access", {29'd0, psel2_o, psel1_o, penable_o}, 32'b011);
    tick();
    check("t1_rsp", {29'd0, rsp_valid_o, rsp_id_o, rsp_err_o}, 32'b100);
    check("t1_rdata", rsp_rdata_o, 32'h0);
    check("t1_idle_bus", {29'd0, psel2_o, psel1_o, penable_o}, 32'b000);
    tick();
    check("t1_rsp_pulse", {31'd0, rsp_valid_o}, 32'h0);

    // 2: req1 read 0x105 from slave2 with two wait states; slave1 ready ignored.
    set_req(1, 1'b0, 32'h105, 32'h0);
    prdata2_i   = 32'h3C;
    req_valid_i = 2'b10;
    #1;
    check("t2_grant", {30'd0, req_grant_o}, 32'h2);
    tick();
    req_valid_i = 2'b00;
    check("t2_setup_sel", {29'd0, psel2_o, psel1_o, penable_o}, 32'b100);
    check("t2_paddr", paddr_o, 32'h05);
    check("t2_pwrite", {31'd0, pwrite_o}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) pready2_i = 1'b1;
      check($sformatf("t2_access%0d", k), {29'd0, psel2_o, psel1_o, penable_o}, 32'b101);
    end
    tick();
    pready2_i = 1'b0;
    check("t2_rsp", {29'd0, rsp_valid_o, rsp_id_o, rsp_err_o}, 32'b110);
    check("t2_rdata", rsp_rdata_o, 32'h3C);
    check("t2_penable_drop", {31'd0, penable_o}, 32'h0);

    // 3: both requesters held valid from reset -> grants 0,1,0,1.
    prst_i = 1'b1;
    tick();
    prst_i = 1'b0;
    set_req(0, 1'b1, 32'h10, 32'h11);
    set_req(1, 1'b1, 32'h120, 32'h22);
    pready1_i   = 1'b1;
    pready2_i   = 1'b1;
    req_valid_i = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_grant%0d", i), {30'd0, req_grant_o}, (i % 2) ? 32'h2 : 32'h1);
      tick();
      check($sformatf("t3_psel_setup%0d", i), {30'd0, psel2_o, psel1_o}, (i % 2) ? 32'h2 : 32'h1);
      tick();
      check($sformatf("t3_psel_access%0d", i), {30'd0, psel2_o, psel1_o}, (i % 2) ? 32'h2 : 32'h1);
      tick();
      if (i == 3) req_valid_i = 2'b00;
      check($sformatf("t3_rsp%0d", i), {30'd0, rsp_valid_o, rsp_id_o}, {30'd0, 1'b1, 1'(i % 2)});
    end
    tick();

    // 4: decode error on address 0x200.
    set_req(0, 1'b0, 32'h200, 32'h0);
    req_valid_i = 2'b01;
    #1;
    check("t4_grant", {30'd0, req_grant_o}, 32'h1);
    tick();
    req_valid_i = 2'b00;
    #1;
    check("t4_no_bus", {29'd0, psel2_o, psel1_o, penable_o}, 32'b000);
    check("t4_rsp", {29'd0, rsp_valid_o, rsp_id_o, rsp_err_o}, 32'b101);
    check("t4_rdata", rsp_rdata_o, 32'h0);
    tick();
    check("t4_no_setup", {30'd0, psel2_o, psel1_o}, 32'h0);

    // 5: slave1 never ready -> timeout after 16 ACCESS cycles.
    pready1_i   = 1'b0;
    prdata1_i   = 32'h77;
    set_req(0, 1'b0, 32'h40, 32'h0);
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();
    cnt = 0;
    while (penable_o && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t5_access_cycles", cnt, 32'd16);
    check("t5_rsp", {29'd0, rsp_valid_o, rsp_id_o, rsp_err_o}, 32'b101);
    check("t5_rdata", rsp_rdata_o, 32'h0);
    check("t5_bus_drop", {29'd0, psel2_o, psel1_o, penable_o}, 32'b000);
    pready1_i   = 1'b1;
    req_valid_i = 2'b01;
    #1;
    check("t5_next_grant", {30'd0, req_grant_o}, 32'h1);
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    check("t5_next_rsp", {29'd0, rsp_valid_o, rsp_id_o, rsp_err_o}, 32'b100);
    check("t5_next_rdata", rsp_rdata_o, 32'h77);

    // 6: reset during ACCESS aborts silently; pointer returns to requester 0.
    pready1_i = 1'b0;
    set_req(0, 1'b1, 32'h08, 32'h5A);
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();
    check("t6_in_access", {31'd0, penable_o}, 32'h1);
    prst_i = 1'b1;
    tick();
    req_valid_i = 2'b11;
    #1;
    check("t6_rst_bus", {29'd0, psel2_o, psel1_o, penable_o}, 32'b000);
    check("t6_rst_rsp", {31'd0, rsp_valid_o}, 32'h0);
    check("t6_rst_grant", {30'd0, req_grant_o}, 32'h0);
    check("t6_rst_paddr", paddr_o, 32'h0);
    prst_i = 1'b0;
    #1;
    check("t6_first_grant", {30'd0, req_grant_o}, 32'h1);
    req_valid_i = 2'b00;
    tick();
    check("t6_no_rsp", {31'd0, rsp_valid_o}, 32'h0);
    tick();
    check("t6_no_rsp2", {31'd0, rsp_valid_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
